// File: rtl/exec_pkg.sv
// Shared op codes, FSM states and constants for the execute stage.
// The optional iterative multiplier is enabled with EXEC_MUL_EN.
package exec_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADD   = 4'd0;
  localparam alu_op_t OP_SUB   = 4'd1;
  localparam alu_op_t OP_AND   = 4'd2;
  localparam alu_op_t OP_OR    = 4'd3;
  localparam alu_op_t OP_XOR   = 4'd4;
  localparam alu_op_t OP_SLL   = 4'd5;
  localparam alu_op_t OP_SRL   = 4'd6;
  localparam alu_op_t OP_SRA   = 4'd7;
  localparam alu_op_t OP_SLT   = 4'd8;
  localparam alu_op_t OP_SLTU  = 4'd9;
  localparam alu_op_t OP_PASSB = 4'd10;
  localparam alu_op_t OP_MUL   = 4'd11;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } ex_state_t;

  localparam int MUL_STEPS = 32;
  localparam int CNT_W     = $clog2(MUL_STEPS);

endpackage

// File: rtl/execute_stage_if.sv
// Upstream inputs and EX/MEM outputs of the execute stage.
// slave is the stage's view, master the driver/consumer view.
interface execute_stage_if
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             valid_in;
  alu_op_t          alu_op_in;
  logic [WIDTH-1:0] operand_a_in;
  logic [WIDTH-1:0] operand_b_in;
  logic [WIDTH-1:0] store_data_in;
  logic [4:0]       rd_in;
  logic             is_load_in;
  logic             is_store_in;
  logic             is_write_in;
  logic             flush_in;

  logic             stall_out;
  logic             valid_out;
  logic [WIDTH-1:0] alu_result_out;
  logic [WIDTH-1:0] write_data_out;
  logic [4:0]       rd_out;
  logic             is_load_out;
  logic             is_store_out;
  logic             is_write_out;

  modport slave (
    input  valid_in, alu_op_in,
    input  operand_a_in, operand_b_in,
    input  store_data_in, rd_in,
    input  is_load_in, is_store_in,
    input  is_write_in, flush_in,
    output stall_out, valid_out,
    output alu_result_out, write_data_out,
    output rd_out, is_load_out,
    output is_store_out, is_write_out
  );

  modport master (
    output valid_in, alu_op_in,
    output operand_a_in, operand_b_in,
    output store_data_in, rd_in,
    output is_load_in, is_store_in,
    output is_write_in, flush_in,
    input  stall_out, valid_out,
    input  alu_result_out, write_data_out,
    input  rd_out, is_load_out,
    input  is_store_out, is_write_out
  );

endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one partial product per step.
// product is the accumulator after the current step is applied.
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  assign product = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: inline ALU feeding the EX/MEM registers.
// EXEC_MUL_EN adds the iterative MUL unit and its stall FSM.
module execute_stage
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  execute_stage_if.slave  bus
);

  logic [WIDTH-1:0] res;
  logic [4:0]       shamt;
  logic             take;

  assign shamt = bus.operand_b_in[4:0];

  always_comb begin
    res = '0;
    case (bus.alu_op_in)
      OP_ADD:   res = bus.operand_a_in + bus.operand_b_in;
      OP_SUB:   res = bus.operand_a_in - bus.operand_b_in;
      OP_AND:   res = bus.operand_a_in & bus.operand_b_in;
      OP_OR:    res = bus.operand_a_in | bus.operand_b_in;
      OP_XOR:   res = bus.operand_a_in ^ bus.operand_b_in;
      OP_SLL:   res = bus.operand_a_in << shamt;
      OP_SRL:   res = bus.operand_a_in >> shamt;
      OP_SRA:   res = $unsigned($signed(bus.operand_a_in) >>> shamt);
      OP_SLT:   res = {{(WIDTH-1){1'b0}},
                       $signed(bus.operand_a_in) < $signed(bus.operand_b_in)};
      OP_SLTU:  res = {{(WIDTH-1){1'b0}},
                       bus.operand_a_in < bus.operand_b_in};
      OP_PASSB: res = bus.operand_b_in;
      default:  res = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_STEPS - 1);

  ex_state_t        state;
  ex_state_t        state_nx;
  logic [CNT_W-1:0] count;
  logic             is_mul;
  logic             start;
  logic             done;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] h_wdata;
  logic [4:0]       h_rd;
  logic             h_load;
  logic             h_store;
  logic             h_write;

  assign is_mul = bus.valid_in && (bus.alu_op_in == OP_MUL);
  assign start  = (state == IDLE) && is_mul && !bus.flush_in;
  assign done   = (state == MUL) && (count == LAST) && !bus.flush_in;
  assign take   = (state == IDLE) && bus.valid_in
                  && !is_mul && !bus.flush_in;

  // Gated by reset so stall drops the moment reset asserts
  assign bus.stall_out = reset && !bus.flush_in &&
    (((state == IDLE) && is_mul) ||
     ((state == MUL) && (count != LAST)));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = MUL;
      MUL:     if (bus.flush_in || count == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      h_wdata <= '0;
      h_rd    <= '0;
      h_load  <= 1'b0;
      h_store <= 1'b0;
      h_write <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        count   <= '0;
        h_wdata <= bus.store_data_in;
        h_rd    <= bus.rd_in;
        h_load  <= bus.is_load_in;
        h_store <= bus.is_store_in;
        h_write <= bus.is_write_in;
      end else if (state == MUL) begin
        count <= count + 1'b1;
      end
    end
  end

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (reset),
    .start   (start),
    .step    (state == MUL),
    .a       (bus.operand_a_in),
    .b       (bus.operand_b_in),
    .product (product)
  );
`else
  assign take          = bus.valid_in && !bus.flush_in;
  assign bus.stall_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.valid_out      <= 1'b0;
      bus.alu_result_out <= '0;
      bus.write_data_out <= '0;
      bus.rd_out         <= '0;
      bus.is_load_out    <= 1'b0;
      bus.is_store_out   <= 1'b0;
      bus.is_write_out   <= 1'b0;
    end else if (take) begin
      bus.valid_out      <= 1'b1;
      bus.alu_result_out <= res;
      bus.write_data_out <= bus.store_data_in;
      bus.rd_out         <= bus.rd_in;
      bus.is_load_out    <= bus.is_load_in;
      bus.is_store_out   <= bus.is_store_in;
      bus.is_write_out   <= bus.is_write_in;
`ifdef EXEC_MUL_EN
    end else if (done) begin
      bus.valid_out      <= 1'b1;
      bus.alu_result_out <= product;
      bus.write_data_out <= h_wdata;
      bus.rd_out         <= h_rd;
      bus.is_load_out    <= h_load;
      bus.is_store_out   <= h_store;
      bus.is_write_out   <= h_write;
`endif
    end else begin
      bus.valid_out    <= 1'b0;
      bus.is_load_out  <= 1'b0;
      bus.is_store_out <= 1'b0;
      bus.is_write_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: vector table, random
// traffic against a reference model, and MUL/flush/reset sequences.
module tb_execute_stage;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  execute_stage_if ex ();

  execute_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ex)
  );

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        ld;
    logic        st;
    logic        wr;
    logic [31:0] res;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] sd, input logic [4:0] rd,
                       input logic ld, input logic st, input logic wr,
                       input logic fl);
    ex.valid_in      = v;
    ex.alu_op_in     = op;
    ex.operand_a_in  = a;
    ex.operand_b_in  = b;
    ex.store_data_in = sd;
    ex.rd_in         = rd;
    ex.is_load_in    = ld;
    ex.is_store_in   = st;
    ex.is_write_in   = wr;
    ex.flush_in      = fl;
  endtask

  task automatic idle;
    drive(1'b0, 4'd0, 0, 0, 0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    longint unsigned p;
    sh = b % 32;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return $unsigned($signed(a) >>> sh);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
`ifdef EXEC_MUL_EN
      4'd11: begin
        p = longint'(a) * longint'(b);
        return p[31:0];
      end
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, ex.valid_out}, 32'd0);
    chk({tag, "_res"}, ex.alu_result_out, 32'd0);
    chk({tag, "_wdata"}, ex.write_data_out, 32'd0);
    chk({tag, "_rd"}, {27'd0, ex.rd_out}, 32'd0);
    chk({tag, "_flags"},
        {29'd0, ex.is_load_out, ex.is_store_out, ex.is_write_out}, 32'd0);
    chk({tag, "_stall"}, {31'd0, ex.stall_out}, 32'd0);
  endtask

`ifdef EXEC_MUL_EN
  task automatic do_mul(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    int n;
    int vld_seen;
    longint unsigned p;
    p = longint'(a) * longint'(b);
    drive(1'b1, OP_MUL, a, b, 32'hCAFE0000 | a, rd, 1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    vld_seen = 0;
    while (ex.stall_out && n < 40) begin
      n++;
      tick;
      if (ex.valid_out) vld_seen++;
    end
    chk({tag, "_stall_cycles"}, n, 32);
    chk({tag, "_bubbles"}, vld_seen, 0);
    tick;
    chk({tag, "_valid"}, {31'd0, ex.valid_out}, 32'd1);
    chk({tag, "_res"}, ex.alu_result_out, p[31:0]);
    chk({tag, "_rd"}, {27'd0, ex.rd_out}, {27'd0, rd});
    chk({tag, "_wdata"}, ex.write_data_out, 32'hCAFE0000 | a);
    chk({tag, "_flags"},
        {29'd0, ex.is_load_out, ex.is_store_out, ex.is_write_out}, 32'd1);
  endtask
`endif

  initial begin
    logic        m_valid;
    logic [31:0] m_res;
    logic [31:0] m_wd;
    logic [4:0]  m_rd;
    logic [2:0]  m_fl;

    tbl[0]  = '{OP_ADD,   32'd7,         32'd5,         32'd0,         5'd3,  1'b0, 1'b0, 1'b1, 32'd12};
    tbl[1]  = '{OP_SUB,   32'd0,         32'd1,         32'd0,         5'd4,  1'b0, 1'b0, 1'b1, 32'hFFFFFFFF};
    tbl[2]  = '{OP_SRA,   32'h80000000,  32'd4,         32'd0,         5'd5,  1'b0, 1'b0, 1'b1, 32'hF8000000};
    tbl[3]  = '{OP_SLT,   32'hFFFFFFFF,  32'd1,         32'd0,         5'd6,  1'b0, 1'b0, 1'b1, 32'd1};
    tbl[4]  = '{OP_SLTU,  32'hFFFFFFFF,  32'd1,         32'd0,         5'd7,  1'b0, 1'b0, 1'b1, 32'd0};
    tbl[5]  = '{OP_ADD,   32'h100,       32'd8,         32'hDEADBEEF,  5'd0,  1'b0, 1'b1, 1'b0, 32'h108};
    tbl[6]  = '{OP_AND,   32'hF0F0F0F0,  32'hFF00FF00,  32'd1,         5'd8,  1'b0, 1'b0, 1'b1, 32'hF000F000};
    tbl[7]  = '{OP_OR,    32'h0F0F0000,  32'h0000F0F0,  32'd2,         5'd9,  1'b0, 1'b0, 1'b1, 32'h0F0FF0F0};
    tbl[8]  = '{OP_XOR,   32'hFFFF0000,  32'h0F0F0F0F,  32'd3,         5'd10, 1'b0, 1'b0, 1'b1, 32'hF0F00F0F};
    tbl[9]  = '{OP_SLL,   32'd1,         32'h0000003F,  32'd4,         5'd11, 1'b0, 1'b0, 1'b1, 32'h80000000};
    tbl[10] = '{OP_SRL,   32'h80000000,  32'h00000021,  32'd5,         5'd12, 1'b0, 1'b0, 1'b1, 32'h40000000};
    tbl[11] = '{OP_PASSB, 32'h55555555,  32'h12345678,  32'd6,         5'd13, 1'b0, 1'b0, 1'b1, 32'h12345678};
    tbl[12] = '{4'd13,    32'd5,         32'd6,         32'd7,         5'd14, 1'b1, 1'b0, 1'b0, 32'd0};
    tbl[13] = '{OP_ADD,   32'h200,       32'd4,         32'd8,         5'd31, 1'b1, 1'b0, 1'b1, 32'h204};

    reset = 1'b0;
    idle;
    #1;
    chk_zero_outputs("reset");
    tick;
    tick;
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sd, tbl[i].rd,
            tbl[i].ld, tbl[i].st, tbl[i].wr, 1'b0);
      #1;
      chk($sformatf("vec%0d_stall", i), {31'd0, ex.stall_out}, 32'd0);
      tick;
      chk($sformatf("vec%0d_valid", i), {31'd0, ex.valid_out}, 32'd1);
      chk($sformatf("vec%0d_res", i), ex.alu_result_out, tbl[i].res);
      chk($sformatf("vec%0d_rd", i), {27'd0, ex.rd_out}, {27'd0, tbl[i].rd});
      chk($sformatf("vec%0d_wdata", i), ex.write_data_out, tbl[i].sd);
      chk($sformatf("vec%0d_flags", i),
          {29'd0, ex.is_load_out, ex.is_store_out, ex.is_write_out},
          {29'd0, tbl[i].ld, tbl[i].st, tbl[i].wr});
    end
    idle;
    tick;
    chk("bubble_valid", {31'd0, ex.valid_out}, 32'd0);
    chk("bubble_hold", ex.alu_result_out, 32'h204);

`ifdef EXEC_MUL_EN
    do_mul("mul_plan", 32'h00010003, 32'h00020005, 5'd9);
    chk("mul_plan_exact", ex.alu_result_out, 32'h000B000F);
    idle;
    tick;
    chk("mul_once", {31'd0, ex.valid_out}, 32'd0);

    do_mul("mul_b2b_a", $urandom, $urandom, 5'd17);
    do_mul("mul_b2b_b", $urandom, $urandom, 5'd18);
    idle;
    tick;

    drive(1'b1, OP_MUL, 32'd1234, 32'd5678, 32'd0, 5'd2,
          1'b0, 1'b0, 1'b1, 1'b0);
    tick;
    for (int k = 0; k < 10; k++) tick;
    chk("flush_pre_stall", {31'd0, ex.stall_out}, 32'd1);
    ex.flush_in = 1'b1;
    #1;
    chk("flush_stall", {31'd0, ex.stall_out}, 32'd0);
    tick;
    idle;
    #1;
    chk("flush_valid", {31'd0, ex.valid_out}, 32'd0);
    chk("flush_idle_stall", {31'd0, ex.stall_out}, 32'd0);
    drive(1'b1, OP_ADD, 32'd40, 32'd2, 32'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick;
    chk("flush_next_add_valid", {31'd0, ex.valid_out}, 32'd1);
    chk("flush_next_add_res", ex.alu_result_out, 32'd42);
    idle;
    tick;

    drive(1'b1, OP_MUL, 32'd3, 32'd3, 32'd0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 32; k++) tick;
    ex.flush_in = 1'b1;
    tick;
    idle;
    chk("flush_at_done", {31'd0, ex.valid_out}, 32'd0);
    tick;
    chk("flush_at_done_after", {31'd0, ex.valid_out}, 32'd0);
`else
    drive(1'b1, OP_MUL, 32'd6, 32'd7, 32'd0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("nomul_stall", {31'd0, ex.stall_out}, 32'd0);
    tick;
    chk("nomul_valid", {31'd0, ex.valid_out}, 32'd1);
    chk("nomul_res", ex.alu_result_out, 32'd0);
    chk("nomul_flags", {31'd0, ex.is_write_out}, 32'd1);
`endif

    drive(1'b1, OP_ADD, 32'd9, 32'd9, 32'd77, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    tick;
    drive(1'b1, OP_MUL, 32'd11, 32'd13, 32'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) tick;
    reset = 1'b0;
    #1;
    chk_zero_outputs("rst_mid");
    reset = 1'b1;
    idle;
    tick;
    chk("rst_mid_after", {31'd0, ex.valid_out}, 32'd0);

    reset = 1'b0;
    #1;
    reset = 1'b1;
    m_valid = 1'b0;
    m_res   = '0;
    m_wd    = '0;
    m_rd    = '0;
    m_fl    = '0;
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b, sd;
      logic [4:0]  rd;
      logic [2:0]  fl;
      logic        v, f;
      op = 4'($urandom_range(0, 15));
`ifdef EXEC_MUL_EN
      if (op == OP_MUL) op = 4'd12;
`endif
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      sd = $urandom;
      rd = 5'($urandom);
      fl = 3'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 7) == 0);
      drive(v, op, a, b, sd, rd, fl[2], fl[1], fl[0], f);
      if (v && !f) begin
        m_valid = 1'b1;
        m_res   = ref_alu(op, a, b);
        m_wd    = sd;
        m_rd    = rd;
        m_fl    = fl;
      end else begin
        m_valid = 1'b0;
        m_fl    = '0;
      end
      #1;
      chk("rnd_stall", {31'd0, ex.stall_out}, 32'd0);
      tick;
      chk("rnd_valid", {31'd0, ex.valid_out}, {31'd0, m_valid});
      chk("rnd_res", ex.alu_result_out, m_res);
      chk("rnd_wdata", ex.write_data_out, m_wd);
      chk("rnd_rd", {27'd0, ex.rd_out}, {27'd0, m_rd});
      chk("rnd_flags",
          {29'd0, ex.is_load_out, ex.is_store_out, ex.is_write_out},
          {29'd0, m_fl});
    end
    idle;

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the multi-cycle pipeline. Sits directly upstream of `memory_stage` and drives its `alu_result_in`, `write_data_in`, `rd_in`, `is_load_in`, `is_store_in` and `is_write_in` from registered outputs, which form the EX/MEM boundary. Single-cycle ALU operations complete in one clock. `MUL` uses an iterative shift-add unit, and the stage stalls upstream while that unit is busy.

## Interface
- `WIDTH`, 32: datapath width. Only 32 is supported.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `valid_in` input 1: an instruction is presented this cycle.
- `alu_op_in` input 4: operation code; encodings are in `exec_pkg`.
- `operand_a_in` input 32: first ALU operand (rs1 value).
- `operand_b_in` input 32: second ALU operand (rs2 value or immediate).
- `store_data_in` input 32: rs2 value, passed through for stores.
- `rd_in` input 5: destination register.
- `is_load_in`, `is_store_in`, `is_write_in` input 1 each: control flags.
- `flush_in` input 1: synchronous kill of the EX contents.
- `stall_out` output 1: combinational; upstream must hold all inputs while it is high.
- `valid_out` output 1: registered; the EX/MEM slot holds a real instruction.
- `alu_result_out` output 32: registered result; also serves as the memory address.
- `write_data_out` output 32: registered store data.
- `rd_out` output 5, plus `is_load_out`, `is_store_out`, `is_write_out` output 1 each: registered.

## Operation
- Op codes:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4
  - SLL=5, SRL=6, SRA=7: shift amount is `operand_b_in[4:0]`.
  - SLT=8 (signed), SLTU=9 (unsigned): result is 0 or 1.
  - PASSB=10: result is `operand_b_in`.
  - MUL=11: result is the low 32 bits of the product.
  - Codes 12–15: result 0; control flags pass through.
- All arithmetic wraps modulo 2^32. No overflow flag.
- FSM states:
  - `IDLE`: an accepted non-MUL op updates all output registers at the next edge.
  - `IDLE`, transition: `valid_in` with `alu_op_in`=MUL and no flush → `MUL` at the next edge. That edge latches the operands, store data, rd and flags, clears the counter, and writes a bubble to the outputs.
  - `MUL`: one shift-add step per edge; counter counts 0..31. At the edge leaving count=31, the outputs take the product with the latched rd and flags, `valid_out`=1, and the state returns to `IDLE`.
- Bubbles: `valid_in`=0, or any bubble cycle, sets `valid_out`=0 and `is_load_out`, `is_store_out`, `is_write_out`=0. Data outputs hold their previous values.
- `stall_out` = (IDLE & `valid_in` & op==MUL & !`flush_in`) | (MUL & count≠31).
- Inputs are ignored while in `MUL`. The held MUL instruction is not re-accepted when the state returns to `IDLE`: upstream advances on the same edge, because `stall_out` is low at count=31.
- `flush_in`, from either state, at the next edge:
  - outputs become a bubble;
  - any MUL in progress is aborted;
  - state → `IDLE`; `stall_out` = 0 in that cycle.
- Flush in the same cycle as MUL completion: flush wins and no result is produced.

## Timing
- Reset (asynchronous, `reset`=0):
  - state `IDLE`, counter 0;
  - all outputs 0, including `valid_out`, flags, `alu_result_out`, `write_data_out` and `rd_out`;
  - `stall_out`=0.
- Reset during `MUL`: the multiply is aborted with no result.
- Single-cycle op presented in cycle C: outputs are valid after edge C+1.
- MUL presented in cycle C0:
  - `stall_out` is high for cycles C0–C31 (32 cycles) and low in C32;
  - result appears after the edge ending C32, i.e. latency 33 edges;
  - `valid_out`=0 during cycles C1–C32.
- Back-to-back MULs: the second is accepted in the cycle after the first result; there is no extra bubble beyond the FSM.

## Configuration
- `EXEC_MUL_EN` defined: the iterative multiplier and the `MUL` state are built.
- Undefined:
  - op 11 behaves like codes 12–15 (result 0, single cycle);
  - `stall_out` is tied 0;
  - the FSM and counter are removed.

## Structure
- `exec_pkg` holds:
  - the `alu_op_t` 4-bit op-code constants;
  - the `ex_state_t` enum (`IDLE`, `MUL`);
  - the `MUL_STEPS`=32 constant.
- Sub-module `mul_iter`: multiplicand/multiplier/accumulator registers, a `start` input, a `step` enable, and a 32-bit product output. It is instantiated only under `EXEC_MUL_EN`.
- The combinational ALU stays inline in `execute_stage`.

## Test plan
- Reset released; ADD 7+5, rd=3, `is_write_in`=1 → next edge: `alu_result_out`=12, `rd_out`=3, `valid_out`=1.
- SUB 0−1 → `alu_result_out`=0xFFFFFFFF. SRA 0x80000000 by 4 → 0xF8000000. SLT −1<1 → 1. SLTU 0xFFFFFFFF<1 → 0.
- MUL 0x0001_0003 × 0x0002_0005 (product 0x2_000B_000F) → `stall_out` high for exactly 32 cycles, then `alu_result_out`=0x000B000F, `valid_out`=1 once.
- MUL in progress, `flush_in` pulsed at count=10 → `valid_out` stays 0, state returns to `IDLE`, and the next ADD completes in 1 cycle.
- Store with base 0x100 + offset 8, `store_data_in`=0xDEADBEEF → `alu_result_out`=0x108, `write_data_out`=0xDEADBEEF, `is_store_out`=1.
- `reset` asserted mid-MUL → all outputs 0 and `stall_out`=0 immediately; `EXEC_MUL_EN` undefined → MUL gives result 0 in 1 cycle with no stall.
